// File: rtl/toast_ex_md_stage_pkg.sv
// Shared encodings for the EX stage: M-extension ops, muldiv FSM states,
// ALU ops, forwarding selects and the pass-through control bundle layout.
package toast_ex_md_stage_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // test_result is the zero flag of the ALU result; branch polarity flips it.
   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_PASS2 = 4'd10
   } alu_op_e;

   localparam logic [1:0] FWD_EX = 2'b10;
   localparam logic [1:0] FWD_WB = 2'b01;

   // Control bundle: {mem_wr, mem_rd, mem_op[1:0], memtoreg, rd_wr, rd[4:0], rs2[4:0]}
   localparam int CTRL_MEM_WR_BIT   = 15;
   localparam int CTRL_MEM_RD_BIT   = 14;
   localparam int CTRL_MEM_OP_LSB   = 12;
   localparam int CTRL_MEMTOREG_BIT = 11;
   localparam int CTRL_RD_WR_BIT    = 10;
   localparam int CTRL_RD_ADDR_LSB  = 5;
   localparam int CTRL_RS2_ADDR_LSB = 0;

   function automatic logic md_a_signed(logic [2:0] op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   function automatic logic md_b_signed(logic [2:0] op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/toast_alu.sv
// Single-cycle integer ALU; test_result is the zero flag used for branches.
module toast_alu
   import toast_ex_md_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      alu_ctrl_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   output logic [XLEN-1:0] result_o,
   output logic            test_result_o
);
   localparam int SW = $clog2(XLEN);

   logic [SW-1:0] shamt;
   assign shamt = op2_i[SW-1:0];

   always_comb begin
      result_o = '0;
      case (alu_ctrl_i)
         ALU_ADD:   result_o = op1_i + op2_i;
         ALU_SUB:   result_o = op1_i - op2_i;
         ALU_AND:   result_o = op1_i & op2_i;
         ALU_OR:    result_o = op1_i | op2_i;
         ALU_XOR:   result_o = op1_i ^ op2_i;
         ALU_SLL:   result_o = op1_i << shamt;
         ALU_SRL:   result_o = op1_i >> shamt;
         ALU_SRA:   result_o = XLEN'($signed(op1_i) >>> shamt);
         ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
         ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, op1_i < op2_i};
         ALU_PASS2: result_o = op2_i;
         default:   result_o = '0;
      endcase
   end

   assign test_result_o = (result_o == '0);
endmodule

// File: rtl/toast_muldiv.sv
// Iterative radix-2 multiply/divide on operand magnitudes, one bit per cycle,
// with sign correction applied to the held result in DONE.
module toast_muldiv
   import toast_ex_md_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int CNT_W = $clog2(XLEN + 1);

   md_state_e         state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_q;
   logic              neg_q, a_neg_q, div0_q;
   logic [XLEN-1:0]   a_q, b_q, hi, lo;

   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag, quo_c, rem_c;
   logic [XLEN:0]     mul_sum, rem_sh, diff;
   logic [2*XLEN-1:0] prod, prod_c;

   assign a_neg = md_a_signed(op_i) & a_i[XLEN-1];
   assign b_neg = md_b_signed(op_i) & b_i[XLEN-1];
   assign a_mag = a_neg ? -a_i : a_i;
   assign b_mag = b_neg ? -b_i : b_i;

   // hi:lo is the product (mul) or remainder:quotient (div)
   assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
   assign rem_sh  = {hi, lo[XLEN-1]};
   assign diff    = rem_sh - {1'b0, b_q};

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state   <= MD_IDLE;
         cnt     <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         a_neg_q <= 1'b0;
         div0_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         hi      <= '0;
         lo      <= '0;
      end else if (flush_i) begin
         state <= MD_IDLE;
      end else begin
         case (state)
            MD_IDLE: if (start_i) begin
               op_q    <= op_i;
               neg_q   <= a_neg ^ b_neg;
               a_neg_q <= a_neg;
               div0_q  <= (b_i == '0);
               a_q     <= a_i;
               b_q     <= b_mag;
               hi      <= '0;
               lo      <= a_mag;
               cnt     <= CNT_W'(XLEN);
               state   <= MD_BUSY;
            end
            MD_BUSY: begin
               if (op_q[2]) begin
                  hi <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                  lo <= {lo[XLEN-2:0], ~diff[XLEN]};
               end else begin
                  hi <= mul_sum[XLEN:1];
                  lo <= {mul_sum[0], lo[XLEN-1:1]};
               end
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= MD_DONE;
            end
            MD_DONE: state <= MD_IDLE;
            default: state <= MD_IDLE;
         endcase
      end
   end

   assign prod   = {hi, lo};
   assign prod_c = neg_q ? -prod : prod;
   assign quo_c  = neg_q ? -lo : lo;
   assign rem_c  = a_neg_q ? -hi : hi;

   always_comb begin
      result_o = '0;
      case (op_q)
         MD_MUL:                      result_o = prod_c[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod_c[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:             result_o = div0_q ? '1 : quo_c;
         default:                     result_o = div0_q ? a_q : rem_c;
      endcase
   end

   assign stall_o = ((state == MD_IDLE) && start_i) || (state == MD_BUSY);
   assign done_o  = (state == MD_DONE);
endmodule

// File: rtl/toast_ex_md_stage.sv
// EX stage: forwarding operand select, single-cycle ALU path and an optional
// iterative M unit that stalls IF/ID until its result is ready.
module toast_ex_md_stage
   import toast_ex_md_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter bit MD_EN  = 1'b1,
   parameter int CTRL_W = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              flush_i,
   input  logic              ID_valid_i,
   input  logic [CTRL_W-1:0] ID_ctrl_i,
   input  logic [3:0]        ID_alu_ctrl_i,
   input  logic              ID_md_en_i,
   input  logic [2:0]        ID_md_op_i,
   input  logic [1:0]        ID_alu_source_sel_i,
   input  logic              ID_jump_en_i,
   input  logic [1:0]        ID_branch_op_i,
   input  logic              ID_branch_flag_i,
   input  logic [XLEN-1:0]   ID_pc_dest_i,
   input  logic [XLEN-1:0]   ID_rs1_data_i,
   input  logic [XLEN-1:0]   ID_rs2_data_i,
   input  logic [XLEN-1:0]   ID_imm1_i,
   input  logic [XLEN-1:0]   ID_imm2_i,
   input  logic [1:0]        forwardA_i,
   input  logic [1:0]        forwardB_i,
   input  logic [XLEN-1:0]   WB_rd_wr_data_i,
   output logic              stall_o,
   output logic              EX_valid_o,
   output logic [CTRL_W-1:0] EX_ctrl_o,
   output logic [XLEN-1:0]   EX_alu_result_o,
   output logic [XLEN-1:0]   EX_rs2_data_o,
   output logic [XLEN-1:0]   EX_pc_dest_o,
   output logic              EX_branch_en_o
);
   logic [XLEN-1:0] op1_mux, op2_mux, op1, op2, rs2_fwd, alu_result, md_result;
   logic            test_result, md_done, unused_bop;

   assign unused_bop = ID_branch_op_i[0];

   always_comb begin
      op1_mux = ID_alu_source_sel_i[1] ? ID_imm1_i : ID_rs1_data_i;
      op2_mux = ID_alu_source_sel_i[0] ? ID_imm2_i : ID_rs2_data_i;
      case (forwardA_i)
         FWD_EX:  op1 = EX_alu_result_o;
         FWD_WB:  op1 = WB_rd_wr_data_i;
         default: op1 = op1_mux;
      endcase
      case (forwardB_i)
         FWD_EX:  begin op2 = EX_alu_result_o; rs2_fwd = EX_alu_result_o; end
         FWD_WB:  begin op2 = WB_rd_wr_data_i; rs2_fwd = WB_rd_wr_data_i; end
         default: begin op2 = op2_mux;         rs2_fwd = ID_rs2_data_i;   end
      endcase
      // jumps compute the link address pc+4 through the ALU
      if (ID_jump_en_i) begin
         op1 = ID_imm1_i;
         op2 = XLEN'(4);
      end
   end

   toast_alu #(.XLEN(XLEN)) u_alu (
      .alu_ctrl_i   (ID_alu_ctrl_i),
      .op1_i        (op1),
      .op2_i        (op2),
      .result_o     (alu_result),
      .test_result_o(test_result)
   );

   if (MD_EN) begin : g_md
      toast_muldiv #(.XLEN(XLEN)) u_muldiv (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .flush_i (flush_i),
         .start_i (ID_valid_i & ID_md_en_i & ~flush_i),
         .op_i    (ID_md_op_i),
         .a_i     (op1),
         .b_i     (op2),
         .stall_o (stall_o),
         .done_o  (md_done),
         .result_o(md_result)
      );
   end else begin : g_no_md
      logic unused_md;
      assign unused_md = ID_md_en_i ^ (^ID_md_op_i);
      assign stall_o   = 1'b0;
      assign md_done   = 1'b0;
      assign md_result = '0;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         EX_valid_o      <= 1'b0;
         EX_ctrl_o       <= '0;
         EX_alu_result_o <= '0;
         EX_rs2_data_o   <= '0;
         EX_pc_dest_o    <= '0;
         EX_branch_en_o  <= 1'b0;
      end else if (flush_i || stall_o) begin
         EX_valid_o     <= 1'b0;
         EX_ctrl_o      <= '0;
         EX_branch_en_o <= 1'b0;
      end else if (md_done) begin
         EX_valid_o      <= 1'b1;
         EX_ctrl_o       <= ID_ctrl_i;
         EX_alu_result_o <= md_result;
         EX_rs2_data_o   <= rs2_fwd;
         EX_pc_dest_o    <= ID_pc_dest_i;
         EX_branch_en_o  <= 1'b0;
      end else begin
         EX_valid_o      <= ID_valid_i;
         EX_ctrl_o       <= ID_valid_i ? ID_ctrl_i : '0;
         EX_alu_result_o <= alu_result;
         EX_rs2_data_o   <= rs2_fwd;
         EX_pc_dest_o    <= ID_pc_dest_i;
         EX_branch_en_o  <= ID_valid_i & ID_branch_op_i[1] & ~ID_jump_en_i
                            & (test_result ^ ID_branch_flag_i);
      end
   end
endmodule

// File: tb/tb_toast_ex_md_stage.sv
// Scoreboard bench for the EX/M stage: directed ALU, branch, M-extension,
// flush and reset vectors with hand-computed results.
module tb_toast_ex_md_stage;
   import toast_ex_md_stage_pkg::*;

   localparam int XLEN = 32;
   localparam int CW   = 16;

   logic            clk = 1'b0, reset_i = 1'b1, flush_i = 1'b0;
   logic            ID_valid_i, ID_md_en_i, ID_jump_en_i, ID_branch_flag_i;
   logic [CW-1:0]   ID_ctrl_i;
   logic [3:0]      ID_alu_ctrl_i;
   logic [2:0]      ID_md_op_i;
   logic [1:0]      ID_alu_source_sel_i, ID_branch_op_i, forwardA_i, forwardB_i;
   logic [XLEN-1:0] ID_pc_dest_i, ID_rs1_data_i, ID_rs2_data_i, ID_imm1_i, ID_imm2_i;
   logic [XLEN-1:0] WB_rd_wr_data_i;
   logic            stall_o, EX_valid_o, EX_branch_en_o;
   logic [CW-1:0]   EX_ctrl_o;
   logic [XLEN-1:0] EX_alu_result_o, EX_rs2_data_o, EX_pc_dest_o;

   toast_ex_md_stage #(.XLEN(XLEN), .MD_EN(1'b1), .CTRL_W(CW)) dut (
      .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
      .ID_valid_i(ID_valid_i), .ID_ctrl_i(ID_ctrl_i), .ID_alu_ctrl_i(ID_alu_ctrl_i),
      .ID_md_en_i(ID_md_en_i), .ID_md_op_i(ID_md_op_i),
      .ID_alu_source_sel_i(ID_alu_source_sel_i), .ID_jump_en_i(ID_jump_en_i),
      .ID_branch_op_i(ID_branch_op_i), .ID_branch_flag_i(ID_branch_flag_i),
      .ID_pc_dest_i(ID_pc_dest_i), .ID_rs1_data_i(ID_rs1_data_i),
      .ID_rs2_data_i(ID_rs2_data_i), .ID_imm1_i(ID_imm1_i), .ID_imm2_i(ID_imm2_i),
      .forwardA_i(forwardA_i), .forwardB_i(forwardB_i),
      .WB_rd_wr_data_i(WB_rd_wr_data_i), .stall_o(stall_o),
      .EX_valid_o(EX_valid_o), .EX_ctrl_o(EX_ctrl_o), .EX_alu_result_o(EX_alu_result_o),
      .EX_rs2_data_o(EX_rs2_data_o), .EX_pc_dest_o(EX_pc_dest_o),
      .EX_branch_en_o(EX_branch_en_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic [XLEN-1:0] res;
      logic            br;
      logic [CW-1:0]   ctrl;
      logic [XLEN-1:0] pc;
   } exp_t;

   exp_t q[$];
   int   total = 0, bad = 0;
   int   seq = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: every presented EX result must match the oldest expectation
   always @(negedge clk) begin
      if (!reset_i && EX_valid_o === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got result %0h expected no output", EX_alu_result_o);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, "_res"},  EX_alu_result_o, e.res);
            chk({e.name, "_br"},   EX_branch_en_o,  e.br);
            chk({e.name, "_ctrl"}, EX_ctrl_o,       e.ctrl);
            chk({e.name, "_pc"},   EX_pc_dest_o,    e.pc);
         end
      end
   end

   task automatic clear_id();
      ID_valid_i = 0; ID_md_en_i = 0; ID_md_op_i = 0; ID_jump_en_i = 0;
      ID_branch_flag_i = 0; ID_branch_op_i = 0; ID_ctrl_i = 0; ID_alu_ctrl_i = 0;
      ID_alu_source_sel_i = 0; forwardA_i = 0; forwardB_i = 0; ID_pc_dest_i = 0;
      ID_rs1_data_i = 0; ID_rs2_data_i = 0; ID_imm1_i = 0; ID_imm2_i = 0;
      WB_rd_wr_data_i = 0;
   endtask

   task automatic alu_op(input string nm, input logic [3:0] alu, input logic [1:0] src,
                         input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                         input logic [XLEN-1:0] imm1, input logic [XLEN-1:0] imm2,
                         input logic [1:0] fa, input logic jmp, input logic [1:0] bop,
                         input logic bflag, input logic [XLEN-1:0] exp_res, input logic exp_br);
      exp_t e;
      seq++;
      ID_valid_i = 1; ID_md_en_i = 0; ID_alu_ctrl_i = alu; ID_alu_source_sel_i = src;
      ID_rs1_data_i = rs1; ID_rs2_data_i = rs2; ID_imm1_i = imm1; ID_imm2_i = imm2;
      forwardA_i = fa; forwardB_i = 2'b00; ID_jump_en_i = jmp; ID_branch_op_i = bop;
      ID_branch_flag_i = bflag; ID_ctrl_i = CW'(16'h1000 + seq);
      ID_pc_dest_i = 32'h300 + 32'(seq);
      e.name = nm; e.res = exp_res; e.br = exp_br; e.ctrl = ID_ctrl_i; e.pc = ID_pc_dest_i;
      q.push_back(e);
      @(posedge clk); #1;
      ID_valid_i = 0;
   endtask

   task automatic md_op(input string nm, input logic [2:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res);
      exp_t e;
      int   n = 0;
      seq++;
      clear_id();
      ID_valid_i = 1; ID_md_en_i = 1; ID_md_op_i = op;
      ID_rs1_data_i = a; ID_rs2_data_i = b;
      ID_ctrl_i = CW'(16'h2000 + seq); ID_pc_dest_i = 32'h500 + 32'(seq);
      e.name = nm; e.res = exp_res; e.br = 1'b0; e.ctrl = ID_ctrl_i; e.pc = ID_pc_dest_i;
      q.push_back(e);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (stall_o) n++;
         else break;
      end
      chk({nm, "_stall_cycles"}, n, XLEN + 1);
      @(posedge clk); #1;
      ID_valid_i = 0; ID_md_en_i = 0;
   endtask

   logic [XLEN-1:0] pc_hold;

   initial begin
      clear_id();
      #2;
      chk("rst_stall", stall_o, 0);
      chk("rst_valid", EX_valid_o, 0);
      chk("rst_result", EX_alu_result_o, 0);
      chk("rst_ctrl", EX_ctrl_o, 0);
      chk("rst_br", EX_branch_en_o, 0);
      chk("rst_pc", EX_pc_dest_o, 0);
      @(posedge clk); #1 reset_i = 0;
      @(posedge clk); #1;

      //       name       alu      src    rs1           rs2    imm1     imm2  fa     j  bop    bf exp           br
      alu_op("add",      ALU_ADD, 2'b00, 32'd5,        32'd7, 0,       0,    2'b00, 0, 2'b00, 0, 32'd12,       0);
      alu_op("sub_imm",  ALU_SUB, 2'b01, 32'd20,       32'd9, 0,       5,    2'b00, 0, 2'b00, 0, 32'd15,       0);
      alu_op("add_imm1", ALU_ADD, 2'b10, 32'd9,        32'h23, 32'h1000, 0,  2'b00, 0, 2'b00, 0, 32'h1023,     0);
      WB_rd_wr_data_i = 32'h40;
      alu_op("fwd_wb",   ALU_ADD, 2'b00, 32'h999,      32'd2, 0,       0,    2'b01, 0, 2'b00, 0, 32'h42,       0);
      alu_op("beq_fwd",  ALU_SUB, 2'b00, 32'h999,      32'h42, 0,      0,    2'b10, 0, 2'b10, 0, 32'h0,        1);
      alu_op("beq_nt",   ALU_SUB, 2'b00, 32'd9,        32'd4, 0,       0,    2'b00, 0, 2'b10, 0, 32'd5,        0);
      alu_op("blt_t",    ALU_SLT, 2'b00, 32'hFFFFFFFD, 32'd2, 0,       0,    2'b00, 0, 2'b10, 1, 32'd1,        1);
      alu_op("jal",      ALU_ADD, 2'b00, 32'd1,        32'd1, 32'h100, 0,    2'b00, 1, 2'b10, 1, 32'h104,      0);

      md_op("mul",      MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
      md_op("div_ovf",  MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      md_op("rem_ovf",  MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0);
      md_op("divu_z",   MD_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF);
      md_op("remu_z",   MD_REMU,   32'd100,      32'd0,        32'd100);
      md_op("mulhu",    MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      md_op("div_neg",  MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
      md_op("rem_neg",  MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
      md_op("div_z",    MD_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
      md_op("rem_z",    MD_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
      md_op("mulh",     MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
      md_op("mulhsu",   MD_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000);

      // flush in BUSY cycle 10 discards the M result
      clear_id();
      ID_valid_i = 1; ID_md_en_i = 1; ID_md_op_i = MD_MUL;
      ID_rs1_data_i = 32'd5; ID_rs2_data_i = 32'd6; ID_pc_dest_i = 32'h777;
      repeat (10) @(posedge clk);
      #1;
      pc_hold = EX_pc_dest_o;
      flush_i = 1; ID_valid_i = 0; ID_md_en_i = 0; ID_pc_dest_i = 32'hDEAD0000;
      @(posedge clk); #1 flush_i = 0;
      @(negedge clk);
      chk("flush_stall", stall_o, 0);
      chk("flush_valid", EX_valid_o, 0);
      chk("flush_pc_hold", EX_pc_dest_o, pc_hold);
      alu_op("add_post_flush", ALU_ADD, 2'b00, 32'd1, 32'd2, 0, 0, 2'b00, 0, 2'b00, 0, 32'd3, 0);

      // flush and M issue together: nothing starts
      clear_id();
      ID_valid_i = 1; ID_md_en_i = 1; ID_md_op_i = MD_MUL;
      ID_rs1_data_i = 32'd5; ID_rs2_data_i = 32'd6; flush_i = 1;
      @(negedge clk);
      chk("flush_issue_stall", stall_o, 0);
      @(posedge clk); #1;
      flush_i = 0; ID_valid_i = 0; ID_md_en_i = 0;
      @(negedge clk);
      chk("flush_issue_idle", stall_o, 0);
      chk("flush_issue_valid", EX_valid_o, 0);

      // asynchronous reset mid-BUSY
      @(posedge clk); #1;
      ID_valid_i = 1; ID_md_en_i = 1; ID_md_op_i = MD_MUL;
      ID_rs1_data_i = 32'd5; ID_rs2_data_i = 32'd6;
      repeat (5) @(posedge clk);
      #2;
      chk("busy_before_rst", stall_o, 1);
      reset_i = 1; ID_valid_i = 0; ID_md_en_i = 0;
      #1;
      chk("arst_stall", stall_o, 0);
      chk("arst_valid", EX_valid_o, 0);
      chk("arst_result", EX_alu_result_o, 0);
      chk("arst_rs2", EX_rs2_data_o, 0);
      chk("arst_pc", EX_pc_dest_o, 0);
      chk("arst_ctrl", EX_ctrl_o, 0);
      chk("arst_br", EX_branch_en_o, 0);
      #1 reset_i = 0;
      @(posedge clk); #1;
      md_op("mul_after_rst", MD_MUL, 32'd3, 32'd3, 32'd9);

      repeat (3) @(negedge clk);
      chk("drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
